pipe_stage_hs: RTL
==================

Name: pipe_stage_hs

Overview:
Next-generation pipeline stage register for the CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries). It carries a parametrised payload bundle with a valid/ready handshake and a two-entry skid buffer, so in_ready is registered and full throughput is kept. It adds synchronous flush for branch/exception squash, and a saturating back-pressure counter for performance monitoring.

Parameters:
DATA_W, 72, payload width in bits (e.g. alu_out + rs2_val + rd + control bits, packed by instantiator)
CNT_W, 16, width of stall_cnt
RST_VAL, 0, reset/flush value loaded into both payload registers (DATA_W bits)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept (registered)
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data valid toward downstream stage
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload to downstream (main register)
stall_clr  input  1  synchronous clear of stall_cnt
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: one clock, asynchronous and active-high. Port names are clk and rst. On rst: state EMPTY, out_valid=0, in_ready=1, out_data=RST_VAL, skid=RST_VAL, stall_cnt=0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States (2-bit): EMPTY (main and skid free), FULL (main holds data), SKID (main and skid hold data).
- out_valid = (state != EMPTY). in_ready = (state != SKID). Both are decoded from registered state only, with no combinational path from inputs.
- EMPTY: if in_fire, main <= in_data and go to FULL. Latency is 1 cycle: data presented in cycle N is on out_data in N+1.
- FULL, in_fire & out_fire: main <= in_data, stay FULL. Throughput is 1 per cycle.
- FULL, in_fire & !out_fire: skid <= in_data, go to SKID.
- FULL, !in_fire & out_fire: go to EMPTY. main keeps its old value, but the value is don't-care.
- FULL, neither: hold.
- SKID: in_ready=0, so no input is accepted. On out_fire: main <= skid, go to FULL. Otherwise hold.
- Ordering is strict FIFO. No payload is duplicated or dropped except by flush.
- flush has priority over every transition:
  - Next state is EMPTY and out_valid=0 the next cycle.
  - A transfer upstream completes in the flush cycle (in_fire=1) is discarded.
  - out_fire in the flush cycle is still a valid handoff to downstream.
  - main and skid are loaded with RST_VAL, so downstream sees clean control bits.
- rst mid-operation: all entries are lost immediately (asynchronous). No partial state survives.
- Payload registers load only on the events above. No enable or clock gating beyond that.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - stall_clr sets it to 0 and wins over increment in the same cycle.
  - flush does not affect it.
  - It counts the registered out_valid of the current cycle.

Decomposition:
- Shared package pipe_pkg holds the state localparams ST_EMPTY=2'b00, ST_FULL=2'b01, ST_SKID=2'b11. Other pipeline blocks reuse the encoding.
- One natural sub-module: sat_counter (parameter W; inputs clk, rst, inc, clr; output cnt), used for stall_cnt and reusable for other performance counters.
- Payload field packing and unpacking lives in the instantiating stage, not here.

Test Plan:
- Reset then streaming: rst pulse, then in_valid=1 with in_data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data 1,2,3,4 one cycle later each. in_ready stays 1 and stall_cnt stays 0.
- Back-pressure/skid: stream 0xA,0xB,0xC with out_ready=0 from the cycle 0xA appears -> 0xA held and 0xB captured in skid. in_ready drops to 0 and 0xC is not accepted until released. After out_ready=1: outputs 0xA,0xB,0xC in order, no loss or duplication.
- Flush: state SKID holding 0x11 (main) and 0x22 (skid), flush=1 with in_valid=1 and in_data=0x33 -> next cycle out_valid=0, in_ready=1, out_data=RST_VAL. 0x33 never emerges.
- Flush with out_fire: FULL holding 0x44, out_ready=1 and flush=1 in the same cycle -> downstream samples 0x44 exactly once, then EMPTY.
- Counter: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. stall_clr=1 for one cycle with the stall still present -> stall_cnt=0, then 1 the following cycle.
- Async reset mid-operation: assert rst between clock edges while in SKID -> out_valid=0, in_ready=1 and stall_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: handshake state encoding and decode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a. Other pipeline blocks reuse this state encoding, so keep it stable.
package pipe_pkg;

  // Stage occupancy state. Bit 0 = main register occupied, bit 1 = skid occupied.
  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'b00;
  localparam pipe_state_t ST_FULL  = 2'b01;
  localparam pipe_state_t ST_SKID  = 2'b11;

  // Downstream-facing valid: anything held in the main register.
  function automatic logic st_has_data(input pipe_state_t st);
    return (st != ST_EMPTY);
  endfunction

  // Upstream-facing ready: a slot is free as long as the skid is unused.
  function automatic logic st_can_accept(input pipe_state_t st);
    return (st != ST_SKID);
  endfunction

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating event counter for performance monitoring.
// Latency: cnt reflects inc/clr of the previous cycle (one register).
// Backpressure: none; stops at all-ones instead of wrapping, clr beats inc.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears cnt
//   inc  - count one event this cycle
//   clr  - synchronous clear, has priority over inc
//   cnt  - current count (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake and two-entry skid buffer.
// Latency: 1 cycle in_data -> out_data; sustains one transfer per cycle.
// Backpressure: in_ready is registered; the skid absorbs the one beat in flight when out_ready drops.
//
// Ports:
//   clk, rst             - clock and asynchronous active-high reset
//   flush                - synchronous squash of all held entries (wins over everything)
//   in_valid/in_ready    - upstream handshake, in_data payload (DATA_W)
//   out_valid/out_ready  - downstream handshake, out_data payload from main register
//   stall_clr/stall_cnt  - clear / value of saturating count of out_valid & !out_ready cycles
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = 72,
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic in_fire;
  logic out_fire;

  // Datapath load controls, decoded alongside the handshake outputs.
  logic load_main;      // main register takes a new value
  logic main_from_skid; // ...and that value comes from the skid, not in_data
  logic load_skid;      // skid captures in_data

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_fire && !out_fire) begin
          state_d = ST_SKID;
        end else if (!in_fire && out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // Skid drains into main; input is blocked in this state.
        if (out_fire) begin
          state_d = ST_FULL;
        end
      end
      default: begin
        // Unused encoding: recover to a clean, empty stage.
        state_d = ST_EMPTY;
      end
    endcase

    // A squash discards everything, including a beat accepted this cycle.
    // A downstream handoff in the same cycle still counts as delivered.
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: handshake from registered state only, load enables per edge
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid      = st_has_data(state_q);
    in_ready       = st_can_accept(state_q);
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;

    unique case (state_q)
      ST_EMPTY: begin
        load_main = in_fire;
      end
      ST_FULL: begin
        // With the consumer taking main this cycle, the new beat replaces it
        // directly; otherwise it parks in the skid behind main.
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
      end
      ST_SKID: begin
        load_main      = out_fire;
        main_from_skid = 1'b1;
      end
      default: begin
        // Illegal state is flushed back to EMPTY above; no payload moves.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
  // On flush both are forced to RST_VAL so stale control bits never leak
  // downstream once the stage refills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= RST_VAL;
    end else if (flush) begin
      main_q <= RST_VAL;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= RST_VAL;
    end else if (flush) begin
      skid_q <= RST_VAL;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  assign out_data = main_q;

  // ---------------------------------------------------------------------------
  // Back-pressure counter: counts cycles the registered out_valid is stalled.
  // Flush does not touch it; only rst and stall_clr clear it.
  // ---------------------------------------------------------------------------
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .clr (stall_clr),
    .cnt (stall_cnt)
  );

endmodule : pipe_stage_hs
